// File: rtl/tl_tx_arb.sv
// Transaction-layer transmit arbiter: shares one TLP stream between the
// posted, non-posted and completion sources under FC credit gating.
module tl_tx_arb #(
    parameter int NSRC           = 3,
    parameter int MAX_PAYLOAD_DW = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NSRC-1:0][127:0]    src_hdr_i,
    input  logic [NSRC-1:0]           src_has_data_i,
    input  logic [NSRC-1:0][255:0]    src_data_i,
    input  logic [NSRC-1:0]           src_valid_i,
    output logic [NSRC-1:0]           src_hdr_ready_o,
    output logic [NSRC-1:0]           src_data_ready_o,
    input  logic [NSRC-1:0]           cred_hdr_ok_i,
    input  logic [NSRC-1:0]           cred_data_ok_i,
    output logic                      cons_valid_o,
    output logic [1:0]                cons_class_o,
    output logic [1:0]                cons_data_units_o,
    output logic [255:0]              tlp_data_o,
    output logic                      tlp_valid_o,
    output logic                      tlp_sop_o,
    output logic                      tlp_eop_o,
    input  logic                      tlp_ready_i
);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  last_q, last_d;
    logic        hd_q, hd_d;
    logic [1:0]  units_q, units_d;

    logic [NSRC-1:0] elig_raw;
    logic [NSRC-1:0] elig;
    logic            p_block;
    logic            pick_vld;
    logic [1:0]      pick;
    logic [9:0]      pick_len;
    logic [9:0]      pick_lenc;
    logic [8:0]      pick_q4;
    logic [1:0]      pick_units;
    logic [NSRC-1:0] gnt_oh;

    function automatic logic [1:0] rr_idx(input logic [1:0] last,
                                          input int k);
        int t;
        t = (int'(last) + k) % NSRC;
        return t[1:0];
    endfunction

    // A credit-blocked posted TLP must not be passed by NP or CPL.
    always_comb begin
        elig_raw = '0;
        for (int i = 0; i < NSRC; i++) begin
            elig_raw[i] = src_valid_i[i] && cred_hdr_ok_i[i] &&
                          (!src_has_data_i[i] || cred_data_ok_i[i]);
        end
        p_block = src_valid_i[0] && !elig_raw[0];
        elig    = p_block ? '0 : elig_raw;
    end

    always_comb begin
        pick_vld = 1'b0;
        pick     = last_q;
        for (int k = NSRC; k >= 1; k--) begin
            if (elig[rr_idx(last_q, k)]) begin
                pick_vld = 1'b1;
                pick     = rr_idx(last_q, k);
            end
        end
    end

    assign pick_len = src_hdr_i[pick][105:96];

    always_comb begin
        pick_lenc = pick_len;
        if (pick_len == '0 || pick_len > 10'(MAX_PAYLOAD_DW)) begin
            pick_lenc = 10'(MAX_PAYLOAD_DW);
        end
        pick_q4    = 9'(({1'b0, pick_lenc} + 11'd3) >> 2);
        pick_units = 2'd0;
        if (src_has_data_i[pick]) begin
            pick_units = (pick_q4 > 9'd2) ? 2'd2 : pick_q4[1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        hd_d    = hd_q;
        units_d = units_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = HDR;
                    gnt_d   = pick;
                    last_d  = pick;
                    hd_d    = src_has_data_i[pick];
                    units_d = pick_units;
                end
            end
            HDR: begin
                if (tlp_ready_i) state_d = hd_q ? DATA : IDLE;
            end
            DATA: begin
                if (tlp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 2'd0;
            last_q  <= 2'd2;
            hd_q    <= 1'b0;
            units_q <= 2'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            hd_q    <= hd_d;
            units_q <= units_d;
        end
    end

    assign gnt_oh = NSRC'(1) << gnt_q;

    // Beat contents come straight from the granted source, which holds them.
    always_comb begin
        tlp_valid_o       = 1'b0;
        tlp_sop_o         = 1'b0;
        tlp_eop_o         = 1'b0;
        tlp_data_o        = '0;
        src_hdr_ready_o   = '0;
        src_data_ready_o  = '0;
        cons_valid_o      = 1'b0;
        cons_class_o      = 2'd0;
        cons_data_units_o = 2'd0;
        unique case (1'b1)
            (state_q == HDR): begin
                tlp_valid_o = 1'b1;
                tlp_sop_o   = 1'b1;
                tlp_eop_o   = !hd_q;
                tlp_data_o  = {src_hdr_i[gnt_q], 128'h0};
                if (tlp_ready_i) begin
                    src_hdr_ready_o   = gnt_oh;
                    cons_valid_o      = 1'b1;
                    cons_class_o      = gnt_q;
                    cons_data_units_o = units_q;
                end
            end
            (state_q == DATA): begin
                tlp_valid_o = 1'b1;
                tlp_eop_o   = 1'b1;
                tlp_data_o  = src_data_i[gnt_q];
                if (tlp_ready_i) src_data_ready_o = gnt_oh;
            end
            default: ;
        endcase
    end

endmodule
